// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, programmable wait states, byte-lane writes.
// Optional macro DMEM_FAULT_EN enables address fault checking (default build: index wraps, no faults).
module dmem_ctrl #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 2048,
   parameter logic [31:0] BASE_ADDR = 32'h10010000,
   parameter int unsigned WAIT_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_fault,
   output logic              busy
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned SHIFT = $clog2(BE_W);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               acc_c;
   logic               accept_c;
   logic [31:0]        off_c;
   logic [IDX_W-1:0]   idx_c;

   logic               we_q;
   logic [IDX_W-1:0]   idx_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [BE_W-1:0]    be_q;
   logic               fault_q;

   logic [DATA_W-1:0]  mem [DEPTH];

   assign accept_c = req_valid && req_ready;
   assign off_c    = req_addr - BASE_ADDR;
   assign idx_c    = IDX_W'(off_c >> SHIFT);

   // Next-state logic; acc_c marks the edge on which the array is accessed
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      acc_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               state_n = S_WAIT;
               cnt_n   = CNT_W'(WAIT_CYC);
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_n = cnt_q - CNT_W'(1);
            end else begin
               acc_c   = 1'b1;
               state_n = S_RESP;
            end
         end
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         busy       <= 1'b0;
         we_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         req_ready  <= (state_n == S_IDLE);
         busy       <= (state_n != S_IDLE);
         resp_valid <= (state_n == S_RESP);
         if (accept_c) begin
            we_q    <= req_we;
            idx_q   <= idx_c;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
         if (acc_c) begin
            resp_rdata <= (we_q || fault_q) ? '0 : mem[idx_q];
         end
      end
   end

`ifdef DMEM_FAULT_EN
   localparam logic [31:0] LOW_MASK = 32'((64'd1 << SHIFT) - 64'd1);
   logic fault_c;

   assign fault_c = (req_addr < BASE_ADDR) ||
                    ((off_c >> SHIFT) >= 32'(DEPTH)) ||
                    ((req_addr & LOW_MASK) != 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q    <= 1'b0;
         resp_fault <= 1'b0;
      end else begin
         if (accept_c) fault_q <= fault_c;
         if (acc_c)    resp_fault <= fault_q;
      end
   end
`else
   assign fault_q    = 1'b0;
   assign resp_fault = 1'b0;
`endif

   // Array is never reset; a write pending when rst hits is dropped
   always_ff @(posedge clk) begin
      if (!rst && acc_c && we_q && !fault_q) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end
endmodule

// File: doc/dmem_ctrl.md
Name:
dmem_ctrl

Overview:
- Parametrised data-memory controller: successor to the fixed single-cycle, word-only data memory that sits behind the CPU's data port.
- Translates CPU byte addresses to word indices using a configurable base address.
- Adds a valid/ready request handshake, a programmable number of wait states, per-byte write enables and a one-cycle response strobe.
- Lets the CPU core run against slower or wider memories without changes to the address-mapping logic at the top level.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8.
- DEPTH, 2048: number of words in the array; must be a power of 2.
- BASE_ADDR, 32'h10010000: byte address that maps to word index 0.
- WAIT_CYC, 1: extra wait cycles per access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte write enables; ignored on reads.
- resp_valid  out  1  one-cycle completion strobe.
- resp_rdata  out  DATA_W  read data; valid while resp_valid=1.
- resp_fault  out  1  access rejected; valid while resp_valid=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, busy=0, wait counter=0.
- Reset does not clear array contents.
- Index computation: off = req_addr - BASE_ADDR (32-bit, wraps); idx = off >> log2(DATA_W/8).
- Handshake: a request is accepted on a posedge where req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - On accept, latch we, idx, wdata and be; load cnt=WAIT_CYC; go to WAIT.
- WAIT state:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the access on this edge and go to RESP.
    - Write: for each byte lane b with be[b]=1, mem[idx][8b+7:8b] <= wdata lane b. be=0 leaves memory unchanged but still produces a response.
    - Read: resp_rdata <= mem[idx].
- RESP state:
  - resp_valid=1 for exactly one cycle, then go to IDLE.
  - resp_rdata is 0 on write responses.
- Latency: resp_valid is high in the cycle after edge (accept edge + WAIT_CYC + 1).
  - Minimum request spacing is WAIT_CYC+3 cycles, because requests are not accepted in RESP.
- Read-after-write to the same idx returns the new data; the write is complete before its response.
- Input changes after acceptance have no effect on the in-flight access.
- Reset mid-operation (WAIT or RESP):
  - Return to IDLE; no response is generated.
  - A write not yet performed is dropped; a write already performed stays in memory.
- Simultaneous rst and req_valid: rst wins; the request is not accepted.

Optional Feature:
- Macro: DMEM_FAULT_EN.
- Defined: a request is faulted if any of the following holds:
  - req_addr < BASE_ADDR;
  - idx >= DEPTH;
  - the low log2(DATA_W/8) address bits are nonzero.
- Faulted requests still go through WAIT and RESP with normal timing; no array access occurs; the response has resp_fault=1 and resp_rdata=0.
- Not defined:
  - idx is taken modulo DEPTH (low log2(DEPTH) bits) and the low address bits are ignored.
  - resp_fault is tied to 0.

Test Plan:
- Defaults, rst held 2 cycles then released → all outputs at reset values; req_ready=1 in the first cycle after release.
- Write 0xDEADBEEF to 0x10010008 with be=4'hF, then read the same address → read resp_rdata=0xDEADBEEF; resp_valid high exactly 1 cycle, at accept edge + 2 cycles (WAIT_CYC=1).
- Word preloaded with 0x11223344, write 0xAABBCCDD with be=4'b0101 → read returns 0x11BB33DD.
- WAIT_CYC=0 and WAIT_CYC=15 builds, read request → resp_valid at accept+1 and accept+16 respectively; req_ready low from the accept edge until IDLE.
- Write accepted, rst asserted during WAIT with cnt>0 → no resp_valid; a later read of that address returns the old data.
- DMEM_FAULT_EN defined, read 0x10010002 and 0x0FFFFFFC → resp_fault=1, resp_rdata=0. Macro undefined, read 0x10012000 → returns word 0 (wrap).
